riscv_mem_responder: RTL and testbench
======================================

RISCV_MEM_RESPONDER -- requirements
Module: riscv_mem_responder

Interface
REQ-001 Parameter: DEPTH, 1024, number of 32-bit words in the storage array.
REQ-002 Parameter: LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-003 Port: clock  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: req_valid  in  1  requester presents a request.
REQ-006 Port: req_ready  out  1  block can accept a request this cycle.
REQ-007 Port: req_write  in  1  1 = store, 0 = load.
REQ-008 Port: req_addr  in  32  byte address.
REQ-009 Port: req_wdata  in  32  store data.
REQ-010 Port: req_wstrb  in  4  byte enables for stores; bit i enables byte i (bits 8i+7:8i).
REQ-011 Port: rsp_valid  out  1  response present.
REQ-012 Port: rsp_ready  in  1  requester accepts the response.
REQ-013 Port: rsp_rdata  out  32  load data; 0 for stores and errors.
REQ-014 Port: rsp_err  out  1  request was misaligned or out of range.

Function
REQ-015 States: IDLE, WAIT, RESP; the block SHALL hold at most one outstanding request.
REQ-016 req_ready SHALL be 1 only in IDLE; it SHALL be combinational from state and SHALL NOT depend on req_valid.
REQ-017 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_write, req_addr, req_wdata and req_wstrb SHALL be captured at that edge.
REQ-018 After acceptance, rsp_valid SHALL first be 1 exactly LATENCY cycles after the acceptance edge. LATENCY=1 SHALL go IDLE->RESP directly; LATENCY>1 SHALL pass through WAIT with a down-counter.
REQ-019 The storage access (read sample or write commit) SHALL occur on the edge that enters RESP.
REQ-020 Word index SHALL be addr[31:2]. Error SHALL be set when addr[1:0]!=0 or index>=DEPTH.
REQ-021 On error, memory SHALL be unchanged, rsp_rdata=0 and rsp_err=1.
REQ-022 A store SHALL update only the enabled bytes. wstrb=0 SHALL be a legal no-op store with rsp_err=0.
REQ-023 A load SHALL return the full word in rsp_rdata with rsp_err=0.
REQ-024 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until the edge where rsp_ready=1; that edge SHALL return the block to IDLE.
REQ-025 rsp_ready may be high before rsp_valid. If rsp_ready=1 in the first RESP cycle, RESP SHALL last exactly one cycle.
REQ-026 No request SHALL be accepted in the cycle the response handshakes. The next acceptance SHALL be possible one cycle later, giving a minimum spacing of LATENCY+1 cycles per transaction.
REQ-027 A load from a word written earlier SHALL return the written data (read-after-write through the array; no bypass is needed because accesses are serialized).
REQ-028 rsp_valid SHALL be 0 in IDLE and WAIT. rsp_rdata and rsp_err SHALL be 0 outside RESP.
REQ-029 req_valid while not ready SHALL be ignored with no side effects. Inputs changing during WAIT or RESP SHALL have no effect.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE, counter=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0, independent of clock.
REQ-031 Reset during WAIT SHALL abort the request. A store not yet committed SHALL NOT modify memory.
REQ-032 Storage array contents SHALL NOT be cleared by reset.
REQ-033 After reset_n rises, req_ready SHALL be 1 in the first cycle.

Verification
REQ-034 LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, rsp_ready=1 -> rsp_valid 2 cycles after acceptance, err=0. A following load of 0x10 -> rdata 0xDEADBEEF.
REQ-035 Partial store to 0x10 with wdata 0x000000AA, wstrb 0x1 -> a load of 0x10 returns 0xDEADBEAA. wstrb 0x0 -> the word is unchanged.
REQ-036 Load addr 0x12 -> rsp_err=1, rdata=0. Store to addr 0x1000 with DEPTH=1024 -> rsp_err=1; words 0..1023 unchanged.
REQ-037 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rdata stable and req_ready=0 throughout. Raise rsp_ready -> IDLE next cycle.
REQ-038 Assert reset_n=0 one cycle after accepting a store of 0x12345678 to 0x20 (LATENCY=3) -> outputs zero immediately. After reset, a load of 0x20 returns the prior contents.
REQ-039 LATENCY=1 with continuous req_valid and rsp_ready -> one transaction every 2 cycles and rsp_valid one cycle after each acceptance.

Source files
------------

// File: rtl/riscv_mem_responder.sv
// Single-outstanding word memory responder with a fixed request-to-response latency.
// Accesses are serialized through an IDLE/WAIT/RESP machine; the array is touched on the edge entering RESP.
module riscv_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;

  logic        write_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [3:0]  wstrb_p0;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        enter_resp;
  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wstrb;
  logic [29:0] acc_idx;
  logic        acc_err;

  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == RESP);
  assign accept     = req_ready & req_valid;
  assign enter_resp = (LATENCY == 1) ? accept : ((state == WAIT) && (cnt == 4'd0));

  // With LATENCY=1 the access happens on the acceptance edge, so the live request is used.
  always_comb begin
    acc_write = write_p0;
    acc_addr  = addr_p0;
    acc_wdata = wdata_p0;
    acc_wstrb = wstrb_p0;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end
    acc_idx = acc_addr[31:2];
    acc_err = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_idx} >= 32'(DEPTH));
  end

  // ---- request capture (stage p0) ----
  always_ff @(posedge clock) begin
    if (accept) begin
      write_p0 <= req_write;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      wstrb_p0 <= req_wstrb;
    end
  end

  // ---- storage commit ----
  always_ff @(posedge clock) begin
    if (enter_resp && acc_write && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) begin
          mem[acc_addr[AW+1:2]][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  // ---- control and response ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        rsp_err   <= acc_err;
        rsp_rdata <= (!acc_write && !acc_err) ? mem[acc_addr[AW+1:2]] : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Scoreboard bench for riscv_mem_responder: three instances at LATENCY 2, 3 and 1.
// Drivers push expected responses; a negedge monitor pops and compares on each response handshake.
module tb_riscv_mem_responder;

  localparam int LATS [3] = '{2, 3, 1};

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n   [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_wstrb [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    riscv_mem_responder #(.DEPTH(1024), .LATENCY(LATS[g])) u_dut (
      .clock    (clock),
      .reset_n  (reset_n[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_write(req_write[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_wstrb(req_wstrb[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sbq [3][$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic prev_v  [3] = '{1'b0, 1'b0, 1'b0};
  int   start_c [3] = '{0, 0, 0};

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one request; the expected response is queued at the cycle before the accepting edge.
  task automatic do_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] er, input logic ee);
    exp_t e;
    int   n;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_wstrb[i] = s;
    req_valid[i] = 1'b1;
    n = 0;
    while (!req_ready[i] && n < 50) begin
      step();
      n++;
    end
    if (!req_ready[i]) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid[i] = 1'b0;
      return;
    end
    e.rdata = er;
    e.err   = ee;
    e.acc   = cyc;
    sbq[i].push_back(e);
    step();
    req_valid[i] = 1'b0;
    // Garbage on the request bus after acceptance must not leak into the access.
    req_write[i] = ~w;
    req_addr[i]  = 32'h0000_0010;
    req_wdata[i] = 32'h0BAD_0BAD;
    req_wstrb[i] = 4'hF;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (!req_ready[i] && n < 100) begin
      step();
      n++;
    end
    if (!req_ready[i]) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int i);
    int n = 0;
    while (!rsp_valid[i] && n < 100) begin
      step();
      n++;
    end
    if (!rsp_valid[i]) check("valid_timeout", 32'd0, 32'd1);
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid[i] && !prev_v[i]) start_c[i] = cyc;
      prev_v[i] = rsp_valid[i];
      if (!rsp_valid[i]) begin
        check("idle_outputs_zero", rsp_rdata[i] | 32'(rsp_err[i]), 32'd0);
      end else if (rsp_ready[i]) begin
        if (sbq[i].size() == 0) begin
          check("unexpected_response", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq[i].pop_front();
          check("rsp_rdata", rsp_rdata[i], e.rdata);
          check("rsp_err", 32'(rsp_err[i]), 32'(e.err));
          check("rsp_latency", 32'(start_c[i] - e.acc), 32'(LATS[i]));
        end
      end
    end
  end

  initial begin
    int accepts;
    for (int i = 0; i < 3; i++) begin
      reset_n[i]   = 1'b0;
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
      req_wstrb[i] = 4'd0;
      rsp_ready[i] = 1'b1;
    end
    repeat (3) step();
    for (int i = 0; i < 3; i++) reset_n[i] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ready_after_reset", 32'(req_ready[i]), 32'd1);
      check("valid_after_reset", 32'(rsp_valid[i]), 32'd0);
    end

    // LATENCY=2: full store, partial store, empty-strobe store, error cases
    do_req(0, 1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
    do_req(0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
    do_req(0, 1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        1'b0);
    do_req(0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0);
    do_req(0, 1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0);
    do_req(0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0);
    do_req(0, 1'b1, 32'h0,   32'h11111111, 4'hF, 32'h0,        1'b0);
    do_req(0, 1'b1, 32'hFFC, 32'h22222222, 4'hF, 32'h0,        1'b0);
    do_req(0, 1'b0, 32'h12,  32'h0,        4'h0, 32'h0,        1'b1);
    do_req(0, 1'b1, 32'h1000, 32'h55555555, 4'hF, 32'h0,       1'b1);
    do_req(0, 1'b1, 32'h11,  32'h66666666, 4'hF, 32'h0,        1'b1);
    do_req(0, 1'b0, 32'h0,   32'h0,        4'h0, 32'h11111111, 1'b0);
    do_req(0, 1'b0, 32'hFFC, 32'h0,        4'h0, 32'h22222222, 1'b0);
    do_req(0, 1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0);

    // Backpressure: five RESP cycles held, then release
    wait_idle(0);
    rsp_ready[0] = 1'b0;
    do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0);
    wait_valid(0);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(rsp_valid[0]), 32'd1);
      check("bp_rdata", rsp_rdata[0], 32'hDEADBEAA);
      check("bp_ready_low", 32'(req_ready[0]), 32'd0);
      step();
    end
    rsp_ready[0] = 1'b1;
    step();
    check("bp_idle_after_release", 32'(req_ready[0]), 32'd1);

    // LATENCY=3: reset during WAIT aborts an uncommitted store
    do_req(1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 32'h0,        1'b0);
    do_req(1, 1'b0, 32'h20, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0);
    wait_idle(1);
    do_req(1, 1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0,        1'b0);
    reset_n[1] = 1'b0;
    #1;
    check("rst_wait_ready", 32'(req_ready[1]), 32'd1);
    check("rst_wait_valid", 32'(rsp_valid[1]), 32'd0);
    check("rst_wait_rdata", rsp_rdata[1] | 32'(rsp_err[1]), 32'd0);
    sbq[1].delete();
    step();
    step();
    reset_n[1] = 1'b1;
    check("ready_after_rst_release", 32'(req_ready[1]), 32'd1);
    do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);

    // Asynchronous reset in the middle of a held response
    wait_idle(1);
    rsp_ready[1] = 1'b0;
    do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);
    wait_valid(1);
    check("held_rdata", rsp_rdata[1], 32'hA5A5A5A5);
    #2;
    reset_n[1] = 1'b0;
    #1;
    check("async_rst_valid", 32'(rsp_valid[1]), 32'd0);
    check("async_rst_rdata", rsp_rdata[1] | 32'(rsp_err[1]), 32'd0);
    sbq[1].delete();
    rsp_ready[1] = 1'b1;
    step();
    reset_n[1] = 1'b1;
    do_req(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'hA5A5A5A5, 1'b0);

    // LATENCY=1: back-to-back loads under continuous req_valid
    do_req(2, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    wait_idle(2);
    req_write[2] = 1'b0;
    req_addr[2]  = 32'h40;
    req_wstrb[2] = 4'h0;
    req_valid[2] = 1'b1;
    accepts = 0;
    for (int k = 0; k < 8; k++) begin
      if (req_ready[2]) begin
        exp_t e;
        e.rdata = 32'hCAFEF00D;
        e.err   = 1'b0;
        e.acc   = cyc;
        sbq[2].push_back(e);
        accepts++;
      end
      step();
    end
    req_valid[2] = 1'b0;
    check("lat1_throughput", 32'(accepts), 32'd4);

    repeat (6) step();
    for (int i = 0; i < 3; i++) check("scoreboard_drained", 32'(sbq[i].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
